lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu.sv | 125 ++++++++++++
 tb/tb_lsu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Size encodings, FSM states and the lane-offset misalignment helper.
package lsu_pkg;

   localparam int LSU_XLEN   = 64;
   localparam int LSU_STRB_W = 8;
   localparam int LSU_OFF_W  = 3;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } lsu_state_e;

   // An access is misaligned when the low address bits covered by its size are nonzero.
   function automatic logic misaligned(lsu_size_e size, logic [LSU_OFF_W-1:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         SZ_W:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data/strobe shifting and load extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN   = LSU_XLEN,
   parameter int STRB_W = LSU_STRB_W
) (
   input  logic [1:0]                 size_i,
   input  logic                       unsigned_i,
   input  logic [$clog2(STRB_W)-1:0]  off_i,
   input  logic [XLEN-1:0]            wdata_i,
   input  logic [XLEN-1:0]            rdata_i,
   output logic [STRB_W-1:0]          wmask_o,
   output logic [XLEN-1:0]            wdata_o,
   output logic [XLEN-1:0]            rdata_o
);

   lsu_size_e         size;
   logic [STRB_W-1:0] base_mask;
   logic [XLEN-1:0]   rshift;
   logic              sext;

   assign size   = lsu_size_e'(size_i);
   assign sext   = ~unsigned_i;
   assign rshift = rdata_i >> {off_i, 3'b000};

   // Lanes shifted past the top of the word are simply dropped by the truncating shift.
   assign wmask_o = base_mask << off_i;
   assign wdata_o = wdata_i << {off_i, 3'b000};

   always_comb begin
      base_mask = '0;
      rdata_o   = rshift;
      case (size)
         SZ_B: begin
            base_mask = STRB_W'(8'h01);
            rdata_o   = {{(XLEN-8){sext & rshift[7]}}, rshift[7:0]};
         end
         SZ_H: begin
            base_mask = STRB_W'(8'h03);
            rdata_o   = {{(XLEN-16){sext & rshift[15]}}, rshift[15:0]};
         end
         SZ_W: begin
            base_mask = STRB_W'(8'h0F);
            rdata_o   = {{(XLEN-32){sext & rshift[31]}}, rshift[31:0]};
         end
         default: begin
            base_mask = STRB_W'(8'hFF);
            rdata_o   = rshift;
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE -> ACCESS -> RESP request FSM with one-cycle memory strobe.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of performing them.
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN   = LSU_XLEN,
   parameter int STRB_W = LSU_STRB_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_addr,
   input  logic              in_wen,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic              out_misalign,
   output logic [XLEN-1:0]   mem_raddr,
   output logic              mem_read,
   output logic [XLEN-1:0]   mem_waddr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [STRB_W-1:0] mem_wmask,
   output logic              mem_write,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic [1:0]        dbg_state_o
);

   localparam int OFF_W = $clog2(STRB_W);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // a response transfers on a rising edge where out_valid && out_ready.

   lsu_state_e        state_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;
   logic [1:0]        size_q;
   logic              wen_q;
   logic              uns_q;
   logic              mis_q;

   logic              accept;
   logic              in_access;
   logic              access_mis;
   logic [OFF_W-1:0]  off;
   logic [STRB_W-1:0] al_wmask;
   logic [XLEN-1:0]   al_wdata;
   logic [XLEN-1:0]   al_rdata;

   assign off = addr_q[OFF_W-1:0];

`ifdef LSU_MISALIGN_CHECK_EN
   assign access_mis = misaligned(lsu_size_e'(size_q), off);
`else
   assign access_mis = 1'b0;
`endif

   lsu_align #(
      .XLEN   (XLEN),
      .STRB_W (STRB_W)
   ) u_align (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .off_i      (off),
      .wdata_i    (wdata_q),
      .rdata_i    (mem_rdata),
      .wmask_o    (al_wmask),
      .wdata_o    (al_wdata),
      .rdata_o    (al_rdata)
   );

   // Outputs are gated by rst so nothing leaks in the reset cycle itself.
   assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && out_ready));
   assign accept    = in_valid && in_ready;
   assign in_access = !rst && (state_q == ST_ACCESS);

   assign mem_read     = in_access && !wen_q && !access_mis;
   assign mem_write    = in_access &&  wen_q && !access_mis;
   assign mem_raddr    = in_access ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign mem_waddr    = mem_raddr;
   assign mem_wmask    = mem_write ? al_wmask : '0;
   assign mem_wdata    = mem_write ? al_wdata : '0;

   assign out_valid    = !rst && (state_q == ST_RESP);
   assign out_rdata    = rst ? '0 : rdata_q;
   assign out_misalign = !rst && mis_q;
   assign dbg_state_o  = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= '0;
         wen_q   <= 1'b0;
         uns_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= in_addr;
         wdata_q <= in_wdata;
         size_q  <= in_size;
         wen_q   <= in_wen;
         uns_q   <= in_unsigned;
         state_q <= ST_ACCESS;
      end else begin
         case (state_q)
            ST_ACCESS: begin
               rdata_q <= (wen_q || access_mis) ? '0 : al_rdata;
               mis_q   <= access_mis;
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; inputs change and outputs are checked on the falling edge.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_wen, in_unsigned;
   logic [63:0] in_addr, in_wdata;
   logic [1:0]  in_size;
   logic        out_valid, out_ready, out_misalign;
   logic [63:0] out_rdata;
   logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;
   logic [7:0]  mem_wmask;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .in_wen       (in_wen),
      .in_size      (in_size),
      .in_unsigned  (in_unsigned),
      .in_wdata     (in_wdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rdata    (out_rdata),
      .out_misalign (out_misalign),
      .mem_raddr    (mem_raddr),
      .mem_read     (mem_read),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_write    (mem_write),
      .mem_rdata    (mem_rdata),
      .dbg_state_o  (dbg_state)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata);
      in_valid    = 1'b1;
      in_wen      = wen;
      in_size     = size;
      in_unsigned = uns;
      in_addr     = addr;
      in_wdata    = wdata;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_size = 2'b00; in_unsigned = 1'b0;
      in_addr = '0; in_wdata = '0; out_ready = 1'b1; mem_rdata = '0;
      @(negedge clk);
      step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
      chk("rst_out_rdata", out_rdata, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
      chk("idle_state", {62'd0, dbg_state}, 64'd0);

      // Load byte signed from lane 3
      req(1'b0, 2'b00, 1'b0, 64'h8000_0003, 64'd0);
      step();
      in_valid  = 1'b0;
      mem_rdata = 64'h0000_0000_80FF_0000;
      #1;
      chk("lb_mem_read", {63'd0, mem_read}, 64'd1);
      chk("lb_mem_write", {63'd0, mem_write}, 64'd0);
      chk("lb_raddr", mem_raddr, 64'h8000_0000);
      chk("lb_valid_early", {63'd0, out_valid}, 64'd0);
      step();
      chk("lb_out_valid", {63'd0, out_valid}, 64'd1);
      chk("lb_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_misalign", {63'd0, out_misalign}, 64'd0);
      chk("lb_read_off", {63'd0, mem_read}, 64'd0);
      step();
      chk("lb_back_idle", {63'd0, out_valid}, 64'd0);

      // Store half at lane 6
      req(1'b1, 2'b01, 1'b0, 64'h8000_0006, 64'h1234);
      step();
      in_valid = 1'b0;
      #1;
      chk("sh_mem_write", {63'd0, mem_write}, 64'd1);
      chk("sh_mem_read", {63'd0, mem_read}, 64'd0);
      chk("sh_wmask", {56'd0, mem_wmask}, 64'h0000_0000_0000_00C0);
      chk("sh_wdata", mem_wdata, 64'h1234_0000_0000_0000);
      chk("sh_waddr", mem_waddr, 64'h8000_0000);
      step();
      chk("sh_write_off", {63'd0, mem_write}, 64'd0);
      chk("sh_wmask_off", {56'd0, mem_wmask}, 64'd0);
      chk("sh_rdata", out_rdata, 64'd0);
      chk("sh_valid", {63'd0, out_valid}, 64'd1);
      step();

      // Load word unsigned from upper half
      req(1'b0, 2'b10, 1'b1, 64'h8000_0004, 64'd0);
      step();
      in_valid  = 1'b0;
      mem_rdata = 64'h8000_0001_DEAD_BEEF;
      step();
      chk("lwu_rdata", out_rdata, 64'h0000_0000_8000_0001);
      step();

      // Load byte unsigned, stall response, then back-to-back store byte
      req(1'b0, 2'b00, 1'b1, 64'h8000_0001, 64'd0);
      step();
      in_valid  = 1'b0;
      mem_rdata = 64'h0000_0000_0000_A500;
      out_ready = 1'b0;
      step();
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", {63'd0, out_valid}, 64'd1);
         chk("stall_rdata", out_rdata, 64'h0000_0000_0000_00A5);
         chk("stall_no_strobe", {62'd0, mem_read, mem_write}, 64'd0);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         step();
      end
      out_ready = 1'b1;
      req(1'b1, 2'b00, 1'b0, 64'h8000_0007, 64'hEE);
      #1;
      chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      #1;
      chk("b2b_write", {63'd0, mem_write}, 64'd1);
      chk("b2b_wmask", {56'd0, mem_wmask}, 64'h0000_0000_0000_0080);
      chk("b2b_wdata", mem_wdata, 64'hEE00_0000_0000_0000);
      chk("b2b_valid_off", {63'd0, out_valid}, 64'd0);
      step();
      chk("b2b_resp", {63'd0, out_valid}, 64'd1);
      step();

      // Reset pulsed during ACCESS abandons the request
      req(1'b0, 2'b11, 1'b0, 64'h8000_0000, 64'd0);
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("rstacc_read", {63'd0, mem_read}, 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rstacc_state", {62'd0, dbg_state}, 64'd0);
      chk("rstacc_mem", {mem_raddr[31:0], 24'd0, mem_wmask} | {62'd0, mem_read, mem_write}, 64'd0);
      chk("rstacc_valid", {63'd0, out_valid}, 64'd0);
      step();
      chk("rstacc_valid2", {63'd0, out_valid}, 64'd0);

      // Load double at a word-aligned, double-misaligned address
      req(1'b0, 2'b11, 1'b0, 64'h8000_0004, 64'd0);
      step();
      in_valid  = 1'b0;
      mem_rdata = 64'h1122_3344_5566_7788;
      #1;
`ifdef LSU_MISALIGN_CHECK_EN
      chk("ld_mis_read", {63'd0, mem_read}, 64'd0);
      step();
      chk("ld_mis_flag", {63'd0, out_misalign}, 64'd1);
      chk("ld_mis_rdata", out_rdata, 64'd0);
`else
      chk("ld_mis_read", {63'd0, mem_read}, 64'd1);
      step();
      chk("ld_mis_flag", {63'd0, out_misalign}, 64'd0);
      chk("ld_mis_rdata", out_rdata, 64'h0000_0000_1122_3344);
`endif
      chk("ld_mis_valid", {63'd0, out_valid}, 64'd1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
